zint_src: RTL and testbench

Interrupt-source generator feeding the Z80 interrupt controller. Tracks the raster position from video line/frame strobes and a pixel clock enable. Emits one-clock `int_start_frm`, `int_start_lin` and `int_start_dma` pulses at CPU-programmed raster positions and at DMA completion. Sits between the video timing/DMA engines and the interrupt controller, which latches these pulses, arbitrates them and drives `~INT`.

---
 rtl/zint_src_pkg.sv | 21 ++
 rtl/zint_src_raster_ctr.sv | 53 +++++
 rtl/zint_src.sv | 97 +++++++++
 tb/tb_zint_src.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zint_src_pkg.sv
// Shared definitions for the Z80 interrupt-source generator: register map,
// default counter widths and the registered pulse bundle.
package zint_src_pkg;

    localparam int ZINT_HW_DEF = 9;
    localparam int ZINT_VW_DEF = 9;

    typedef enum logic [1:0] {
        ZINT_HSINT  = 2'd0,
        ZINT_VSINTL = 2'd1,
        ZINT_VSINTH = 2'd2,
        ZINT_RSVD   = 2'd3
    } zint_reg_e;

    typedef struct packed {
        logic frm;
        logic lin;
        logic dma;
    } zint_irq_t;

endpackage

// File: rtl/zint_src_raster_ctr.sv
// Raster position counters: horizontal in pixel tacts, vertical in lines.
// Both saturate at all-ones so a missing strobe never wraps into a false match.
module raster_ctr
    import zint_src_pkg::*;
#(
    parameter int HW = ZINT_HW_DEF,
    parameter int VW = ZINT_VW_DEF
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          ce_i,
    input  logic          line_start_i,
    input  logic          frame_start_i,
    output logic [HW-1:0] hcnt_o,
    output logic [VW-1:0] vcnt_o
);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        // The line strobe wins over a coincident pixel tact.
        if (line_start_i) begin
            hcnt_d = '0;
        end else if (ce_i && (hcnt_q != '1)) begin
            hcnt_d = hcnt_q + HW'(1);
        end
        if (frame_start_i) begin
            vcnt_d = '0;
        end else if (line_start_i && (vcnt_q != '1)) begin
            vcnt_d = vcnt_q + VW'(1);
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!res_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o = hcnt_q;
    assign vcnt_o = vcnt_q;

endmodule

// File: rtl/zint_src.sv
// Interrupt-source generator: frame/line INT at programmed raster positions
// and a DMA-end INT, each a registered single-clock pulse. Requires VW >= 9.
module zint_src
    import zint_src_pkg::*;
#(
    parameter int HW = ZINT_HW_DEF,
    parameter int VW = ZINT_VW_DEF
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       ce,
    input  logic       line_start,
    input  logic       frame_start,
    input  logic       dma_act,
    input  logic       regwr,
    input  logic [1:0] regaddr,
    input  logic [7:0] regdata,
    output logic       int_start_frm,
    output logic       int_start_lin,
    output logic       int_start_dma
);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hm;

    logic [7:0]    hint_q, hint_d;
    logic [VW-1:0] vint_wr_q, vint_wr_d;
    logic [VW-1:0] vint_q, vint_d;
    logic          armed_q, armed_d;
    logic          dma_r_q;
    zint_irq_t     irq_q, irq_d;

    raster_ctr #(
        .HW(HW),
        .VW(VW)
    ) u_raster (
        .clk           (clk),
        .res_n         (res_n),
        .ce_i          (ce),
        .line_start_i  (line_start),
        .frame_start_i (frame_start),
        .hcnt_o        (hcnt),
        .vcnt_o        (vcnt)
    );

    always_comb begin
        // hcnt moves on every match tact, so each line yields at most one hm.
        hm        = ce && !line_start && (hcnt == HW'({hint_q, 1'b0}));
        irq_d.lin = hm;
        irq_d.frm = hm && (vcnt == vint_q) && armed_q;
        irq_d.dma = dma_r_q && !dma_act;

        hint_d    = hint_q;
        vint_wr_d = vint_wr_q;
        if (regwr) begin
            case (zint_reg_e'(regaddr))
                ZINT_HSINT:  hint_d          = regdata;
                ZINT_VSINTL: vint_wr_d[7:0]  = regdata;
                ZINT_VSINTH: vint_wr_d[8]    = regdata[0];
                default:     ;
            endcase
        end

        // VSINT is shadowed so a mid-frame rewrite only applies from the next frame.
        vint_d  = frame_start ? vint_wr_q : vint_q;
        armed_d = armed_q;
        if (frame_start) begin
            armed_d = 1'b1;
        end else if (irq_d.frm) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            hint_q    <= '0;
            vint_wr_q <= '0;
            vint_q    <= '0;
            armed_q   <= 1'b0;
            dma_r_q   <= 1'b0;
            irq_q     <= '0;
        end else begin
            hint_q    <= hint_d;
            vint_wr_q <= vint_wr_d;
            vint_q    <= vint_d;
            armed_q   <= armed_d;
            dma_r_q   <= dma_act;
            irq_q     <= irq_d;
        end
    end

    assign int_start_frm = irq_q.frm;
    assign int_start_lin = irq_q.lin;
    assign int_start_dma = irq_q.dma;

endmodule

// File: tb/tb_zint_src.sv
// Self-checking bench for zint_src: per-cycle scoreboard against a behavioural
// raster model, a hand-computed vector table and directed raster sequences.
module tb_zint_src;
    import zint_src_pkg::*;

    logic       clk = 1'b0;
    logic       res_n;
    logic       ce, line_start, frame_start, dma_act, regwr;
    logic [1:0] regaddr;
    logic [7:0] regdata;
    logic       int_start_frm, int_start_lin, int_start_dma;

    always #5 clk = ~clk;

    zint_src dut (
        .clk           (clk),
        .res_n         (res_n),
        .ce            (ce),
        .line_start    (line_start),
        .frame_start   (frame_start),
        .dma_act       (dma_act),
        .regwr         (regwr),
        .regaddr       (regaddr),
        .regdata       (regdata),
        .int_start_frm (int_start_frm),
        .int_start_lin (int_start_lin),
        .int_start_dma (int_start_dma)
    );

    typedef struct {
        logic       ce, ls, fs, dma, wr;
        logic [1:0] addr;
        logic [7:0] data;
    } inp_t;

    typedef struct {
        logic frm, lin, dma;
    } exp_t;

    typedef struct {
        inp_t in;
        exp_t e;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t obs;
    exp_t no_exp;

    int   m_hcnt, m_vcnt, m_hint, m_vint_wr, m_vint;
    bit   m_armed, m_dma_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic inp_t mk_in(input logic c, input logic ls, input logic fs, input logic d,
                                   input logic w, input logic [1:0] a, input logic [7:0] dat);
        inp_t r;
        r.ce = c; r.ls = ls; r.fs = fs; r.dma = d; r.wr = w; r.addr = a; r.data = dat;
        return r;
    endfunction

    function automatic vec_t mk_v(input logic c, input logic ls, input logic fs, input logic d,
                                  input logic w, input logic [1:0] a, input logic [7:0] dat,
                                  input logic ef, input logic el, input logic ed);
        vec_t v;
        v.in = mk_in(c, ls, fs, d, w, a, dat);
        v.e.frm = ef; v.e.lin = el; v.e.dma = ed;
        return v;
    endfunction

    task automatic model_reset();
        m_hcnt = 0; m_vcnt = 0; m_hint = 0; m_vint_wr = 0; m_vint = 0;
        m_armed = 1'b0; m_dma_r = 1'b0;
        sb_q.delete();
    endtask

    // Behavioural raster model: expected pulses for this clock, then state update.
    task automatic model_step(input inp_t in, output exp_t e);
        e.lin = in.ce && !in.ls && (m_hcnt == 2 * m_hint);
        e.frm = e.lin && (m_vcnt == m_vint) && m_armed;
        e.dma = m_dma_r && !in.dma;
        if (in.fs) begin
            m_vint  = m_vint_wr;
            m_armed = 1'b1;
        end else if (e.frm) begin
            m_armed = 1'b0;
        end
        if (in.ls) m_hcnt = 0;
        else if (in.ce && m_hcnt < 511) m_hcnt++;
        if (in.fs) m_vcnt = 0;
        else if (in.ls && m_vcnt < 511) m_vcnt++;
        if (in.wr) begin
            case (in.addr)
                2'd0: m_hint = int'(in.data);
                2'd1: m_vint_wr = (m_vint_wr & 256) | int'(in.data);
                2'd2: m_vint_wr = (m_vint_wr & 255) | (in.data[0] ? 256 : 0);
                default: ;
            endcase
        end
        m_dma_r = in.dma;
    endtask

    task automatic cycle(input inp_t in, input bit use_tbl, input exp_t tbl_e, input string name);
        exp_t e, req;
        model_step(in, e);
        if (use_tbl) e = tbl_e;
        ce = in.ce; line_start = in.ls; frame_start = in.fs; dma_act = in.dma;
        regwr = in.wr; regaddr = in.addr; regdata = in.data;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        obs.frm = int_start_frm; obs.lin = int_start_lin; obs.dma = int_start_dma;
        req = sb_q.pop_front();
        check(name, {29'd0, obs.frm, obs.lin, obs.dma}, {29'd0, req.frm, req.lin, req.dma});
    endtask

    task automatic run(input logic c, input logic ls, input logic fs, input logic d, input string name);
        cycle(mk_in(c, ls, fs, d, 1'b0, 2'd0, 8'd0), 1'b0, no_exp, name);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] dat);
        cycle(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, dat), 1'b0, no_exp, "reg_write");
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        ce = 0; line_start = 0; frame_start = 0; dma_act = 0; regwr = 0; regaddr = 0; regdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {29'd0, int_start_frm, int_start_lin, int_start_dma}, 32'd0);
        res_n = 1'b1;
    endtask

    // Two frames of 300 lines x 16 clk, hint=5 so hm lands at clk 11 of each line.
    task automatic frame_run(input int exp_l0, input int exp_l1, input bit rewrite, input string tag);
        int   frm_cnt, frm_line;
        inp_t in;
        for (int f = 0; f < 2; f++) begin
            frm_cnt = 0;
            frm_line = -1;
            for (int l = 0; l < 300; l++) begin
                for (int k = 0; k < 16; k++) begin
                    in = mk_in(1'b1, k == 0, (k == 0) && (l == 0), 1'b0, 1'b0, 2'd0, 8'd0);
                    if (rewrite && f == 0 && l == 100 && (k == 3 || k == 4)) begin
                        in.wr   = 1'b1;
                        in.addr = (k == 3) ? ZINT_VSINTL : ZINT_VSINTH;
                    end
                    cycle(in, 1'b0, no_exp, {tag, "_cycle"});
                    if (obs.frm === 1'b1) begin
                        frm_cnt++;
                        frm_line = l;
                        check({tag, "_frm_with_lin"}, {31'd0, obs.lin}, 32'd1);
                    end
                end
            end
            check({tag, "_frm_count"}, frm_cnt, 1);
            check({tag, "_frm_line"}, frm_line, (f == 0) ? exp_l0 : exp_l1);
        end
    endtask

    vec_t tbl[15];

    initial begin
        int cnt, cnt2, p1, p2;
        no_exp.frm = 0; no_exp.lin = 0; no_exp.dma = 0;
        res_n = 1'b0;
        do_reset();

        // Hand-computed vectors from reset: priority, old-hint on write, DMA glitch,
        // ignored address 3, frame INT on line 0 with vint=0.
        tbl[0]  = mk_v(1, 1, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0);
        tbl[1]  = mk_v(1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 1, 0);
        tbl[2]  = mk_v(1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0);
        tbl[3]  = mk_v(0, 0, 0, 0, 1, 2'd0, 8'h01, 0, 0, 0);
        tbl[4]  = mk_v(1, 0, 0, 0, 1, 2'd0, 8'h05, 0, 1, 0);
        tbl[5]  = mk_v(0, 1, 1, 1, 0, 2'd0, 8'h00, 0, 0, 0);
        tbl[6]  = mk_v(1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 1);
        tbl[7]  = mk_v(0, 0, 0, 1, 0, 2'd0, 8'h00, 0, 0, 0);
        tbl[8]  = mk_v(0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 1);
        tbl[9]  = mk_v(0, 0, 0, 0, 1, 2'd0, 8'h00, 0, 0, 0);
        tbl[10] = mk_v(0, 0, 0, 0, 1, 2'd3, 8'hFF, 0, 0, 0);
        tbl[11] = mk_v(0, 1, 1, 0, 0, 2'd0, 8'h00, 0, 0, 0);
        tbl[12] = mk_v(1, 0, 0, 0, 0, 2'd0, 8'h00, 1, 1, 0);
        tbl[13] = mk_v(0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0);
        tbl[14] = mk_v(1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].in, 1'b1, tbl[i].e, $sformatf("tbl_vec%0d", i));
        end

        // Priority: line_start + ce while hcnt == {hint,0} (hcnt=1 here, hint -> 2).
        wr_reg(ZINT_HSINT, 8'h02);
        repeat (3) run(1, 0, 0, 0, "prio_pre");
        run(1, 1, 0, 0, "prio_cycle");
        check("prio_no_lin", {31'd0, obs.lin}, 32'd0);
        check("prio_hcnt", 32'(dut.hcnt), 32'd0);

        // Line INT: hint=0x10, 10 lines of 448 clk.
        do_reset();
        wr_reg(ZINT_HSINT, 8'h10);
        cnt = 0;
        for (int l = 0; l < 10; l++) begin
            for (int k = 0; k < 448; k++) begin
                run(1, k == 0, 0, 0, "line_cycle");
                if (obs.lin === 1'b1) begin
                    cnt++;
                    check("line_pulse_offset", k, 33);
                end
            end
        end
        check("line_pulse_count", cnt, 10);

        // Frame INT at VSINT=0x120, then rewrite to 0 mid-frame.
        do_reset();
        wr_reg(ZINT_VSINTL, 8'h20);
        wr_reg(ZINT_VSINTH, 8'h01);
        wr_reg(ZINT_HSINT, 8'h05);
        frame_run(288, 288, 1'b0, "frmA");
        frame_run(288, 0, 1'b1, "frmB");

        // Saturation: one line_start, then 600 tacts.
        do_reset();
        wr_reg(ZINT_HSINT, 8'h10);
        run(0, 1, 0, 0, "sat_ls");
        cnt = 0;
        repeat (600) begin
            run(1, 0, 0, 0, "sat_cycle");
            if (obs.lin === 1'b1) cnt++;
        end
        check("sat_lin_count", cnt, 1);
        check("sat_hcnt", 32'(dut.hcnt), 32'd511);

        // DMA: long busy then a 1-clk glitch.
        do_reset();
        repeat (50) run(0, 0, 0, 1, "dma_busy");
        cnt = 0; p1 = -1; p2 = -1;
        for (int i = 0; i < 5; i++) begin
            run(0, 0, 0, 0, "dma_idle1");
            if (obs.dma === 1'b1) begin cnt++; p1 = i; end
        end
        run(0, 0, 0, 1, "dma_glitch");
        for (int i = 0; i < 5; i++) begin
            run(0, 0, 0, 0, "dma_idle2");
            if (obs.dma === 1'b1) begin cnt++; p2 = i; end
        end
        check("dma_pulse_count", cnt, 2);
        check("dma_first_latency", p1, 0);
        check("dma_second_latency", p2, 0);

        // Reset mid-line with dma_act=1 and a frame pulse in flight.
        do_reset();
        run(0, 1, 1, 0, "rst_fs");
        run(1, 0, 0, 1, "rst_pre");
        check("rst_pre_frm", {31'd0, obs.frm}, 32'd1);
        #2 res_n = 1'b0;
        #1 check("rst_async_outputs", {29'd0, int_start_frm, int_start_lin, int_start_dma}, 32'd0);
        model_reset();
        ce = 0; line_start = 0; frame_start = 0; regwr = 0;
        @(posedge clk);
        #1;
        check("rst_hold_outputs", {29'd0, int_start_frm, int_start_lin, int_start_dma}, 32'd0);
        res_n = 1'b1;
        cnt = 0;
        repeat (3) begin
            run(1, 0, 0, 1, "rst_unarmed");
            if (obs.frm === 1'b1) cnt++;
        end
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < 8; k++) begin
                run(1, k == 0, 0, (l == 0), "rst_lines");
                if (obs.frm === 1'b1) cnt++;
            end
        end
        check("rst_no_frm_before_fs", cnt, 0);
        cnt2 = 0;
        run(0, 1, 1, 0, "rst_fs2");
        run(1, 0, 0, 0, "rst_post_fs");
        if (obs.frm === 1'b1) cnt2++;
        check("rst_frm_after_fs", cnt2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
